em_pipeline_reg: RTL and testbench

//   E->M pipeline register of the 5-stage MIPS pipeline. Captures E-stage results each cycle and

---
 rtl/em_pipeline_reg.sv | 67 ++++++
 tb/tb_em_pipeline_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/em_pipeline_reg.sv
// em_pipeline_reg: E->M pipeline register with stall/flush/req bubbles and M-stage forwarding bundle
module em_pipeline_reg #(
   parameter logic [31:0] EXC_PC = 32'h0000_4180,
   parameter int          TNEW_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              flush,
   input  logic              stall,
   input  logic [31:0]       E_PC,
   input  logic [31:0]       E_Instr,
   input  logic [31:0]       E_ALU_Result,
   input  logic [31:0]       E_MDU_Out,
   input  logic [31:0]       E_Mem_WData,
   input  logic [4:0]        E_Reg_Addr,
   input  logic              E_Reg_WriteEn,
   input  logic [1:0]        E_Reg_Data_Sel,
   input  logic [TNEW_W-1:0] E_T_new,
   input  logic [4:0]        E_ExcCode,
   input  logic              E_BD,
   output logic [31:0]       M_PC,
   output logic [31:0]       M_Instr,
   output logic [31:0]       M_ALU_Result,
   output logic [31:0]       M_Mem_WData,
   output logic [4:0]        M_ExcCode,
   output logic              M_BD,
   output logic [4:0]        FWD_M_Reg_Addr,
   output logic [31:0]       FWD_M_Reg_Data,
   output logic [TNEW_W-1:0] FWD_M_T_new,
   output logic              FWD_M_Reg_WriteEn
);
   logic              we_eff;
   logic [31:0]       fwd_data;
   logic [TNEW_W-1:0] tnew_aged;
   always_comb begin
      we_eff    = E_Reg_WriteEn && (E_Reg_Addr != 5'd0);
      fwd_data  = (E_Reg_Data_Sel == 2'b01) ? E_PC + 32'd8 :
                  (E_Reg_Data_Sel == 2'b10) ? E_MDU_Out : E_ALU_Result;
      tnew_aged = (E_T_new == '0) ? '0 : E_T_new - TNEW_W'(1);
   end
   always_ff @(posedge clk) begin
      if (reset || req || flush) begin
         M_PC              <= reset ? 32'd0 : req ? EXC_PC : E_PC;
         M_BD              <= !reset && !req && E_BD;
         M_Instr           <= '0;
         M_ALU_Result      <= '0;
         M_Mem_WData       <= '0;
         M_ExcCode         <= '0;
         FWD_M_Reg_Addr    <= '0;
         FWD_M_Reg_Data    <= '0;
         FWD_M_T_new       <= '0;
         FWD_M_Reg_WriteEn <= 1'b0;
      end else if (!stall) begin
         M_PC              <= E_PC;
         M_BD              <= E_BD;
         M_Instr           <= E_Instr;
         M_ALU_Result      <= E_ALU_Result;
         M_Mem_WData       <= E_Mem_WData;
         M_ExcCode         <= E_ExcCode;
         FWD_M_Reg_Addr    <= we_eff ? E_Reg_Addr : 5'd0;
         FWD_M_Reg_Data    <= fwd_data;
         FWD_M_T_new       <= tnew_aged;
         FWD_M_Reg_WriteEn <= we_eff;
      end
   end
endmodule

// File: tb/tb_em_pipeline_reg.sv
// tb_em_pipeline_reg: directed and random checks of em_pipeline_reg against a spec-level model
module tb_em_pipeline_reg;
   localparam logic [31:0] EXC = 32'h0000_4180;
   logic clk = 1'b0;
   logic reset, req, flush, stall;
   logic [31:0] E_PC, E_Instr, E_ALU_Result, E_MDU_Out, E_Mem_WData;
   logic [4:0]  E_Reg_Addr, E_ExcCode;
   logic        E_Reg_WriteEn, E_BD;
   logic [1:0]  E_Reg_Data_Sel;
   logic [2:0]  E_T_new;
   logic [31:0] M_PC, M_Instr, M_ALU_Result, M_Mem_WData, FWD_M_Reg_Data;
   logic [4:0]  M_ExcCode, FWD_M_Reg_Addr;
   logic        M_BD, FWD_M_Reg_WriteEn;
   logic [2:0]  FWD_M_T_new;
   int errors = 0;
   int checks = 0;
   typedef struct {
      logic [31:0] pc, instr, alu, wd, data;
      logic [4:0]  exc, addr;
      logic        bd, we;
      logic [2:0]  tnew;
   } m_t;
   m_t exp_m;
   em_pipeline_reg dut (
      .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
      .E_PC(E_PC), .E_Instr(E_Instr), .E_ALU_Result(E_ALU_Result), .E_MDU_Out(E_MDU_Out),
      .E_Mem_WData(E_Mem_WData), .E_Reg_Addr(E_Reg_Addr), .E_Reg_WriteEn(E_Reg_WriteEn),
      .E_Reg_Data_Sel(E_Reg_Data_Sel), .E_T_new(E_T_new), .E_ExcCode(E_ExcCode), .E_BD(E_BD),
      .M_PC(M_PC), .M_Instr(M_Instr), .M_ALU_Result(M_ALU_Result), .M_Mem_WData(M_Mem_WData),
      .M_ExcCode(M_ExcCode), .M_BD(M_BD), .FWD_M_Reg_Addr(FWD_M_Reg_Addr),
      .FWD_M_Reg_Data(FWD_M_Reg_Data), .FWD_M_T_new(FWD_M_T_new),
      .FWD_M_Reg_WriteEn(FWD_M_Reg_WriteEn)
   );
   always #5 clk = ~clk;
   function automatic m_t bubble(input logic [31:0] pc, input logic bd);
      m_t b;
      b = '{pc: pc, instr: 0, alu: 0, wd: 0, data: 0, exc: 0, addr: 0, bd: bd, we: 0, tnew: 0};
      return b;
   endfunction
   // Next M contents from the current E inputs, controls and the held M contents.
   function automatic m_t model(input m_t cur);
      m_t n;
      int remaining;
      if (reset) return bubble(32'd0, 1'b0);
      if (req) return bubble(EXC, 1'b0);
      if (flush) return bubble(E_PC, E_BD);
      if (stall) return cur;
      n.pc = E_PC;
      n.instr = E_Instr;
      n.alu = E_ALU_Result;
      n.wd = E_Mem_WData;
      n.exc = E_ExcCode;
      n.bd = E_BD;
      case (E_Reg_Data_Sel)
         2'd1:    n.data = E_PC + 32'd8;
         2'd2:    n.data = E_MDU_Out;
         default: n.data = E_ALU_Result;
      endcase
      remaining = int'(E_T_new) - 1;
      n.tnew = (remaining < 0) ? 3'd0 : 3'(remaining);
      n.we = E_Reg_WriteEn && E_Reg_Addr != 0;
      n.addr = n.we ? E_Reg_Addr : 5'd0;
      return n;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask
   task automatic chk_model();
      chk("M_PC", M_PC, exp_m.pc);
      chk("M_Instr", M_Instr, exp_m.instr);
      chk("M_ALU_Result", M_ALU_Result, exp_m.alu);
      chk("M_Mem_WData", M_Mem_WData, exp_m.wd);
      chk("M_ExcCode", {27'd0, M_ExcCode}, {27'd0, exp_m.exc});
      chk("M_BD", {31'd0, M_BD}, {31'd0, exp_m.bd});
      chk("FWD_M_Reg_Addr", {27'd0, FWD_M_Reg_Addr}, {27'd0, exp_m.addr});
      chk("FWD_M_Reg_Data", FWD_M_Reg_Data, exp_m.data);
      chk("FWD_M_T_new", {29'd0, FWD_M_T_new}, {29'd0, exp_m.tnew});
      chk("FWD_M_Reg_WriteEn", {31'd0, FWD_M_Reg_WriteEn}, {31'd0, exp_m.we});
   endtask
   task automatic cycle();
      exp_m = model(exp_m);
      @(posedge clk);
      #1;
      chk_model();
   endtask
   task automatic rand_e();
      E_PC = $urandom;
      E_Instr = $urandom;
      E_ALU_Result = $urandom;
      E_MDU_Out = $urandom;
      E_Mem_WData = $urandom;
      E_Reg_Addr = 5'($urandom);
      E_Reg_WriteEn = 1'($urandom);
      E_Reg_Data_Sel = 2'($urandom);
      E_T_new = 3'($urandom);
      E_ExcCode = 5'($urandom);
      E_BD = 1'($urandom);
   endtask
   initial begin
      exp_m = bubble(32'd0, 1'b0);
      {req, flush, stall} = 3'b000;
      reset = 1'b1;
      rand_e();
      cycle();
      rand_e();
      cycle();
      chk("rst_pc", M_PC, 32'd0);
      chk("rst_we", {31'd0, FWD_M_Reg_WriteEn}, 32'd0);
      reset = 1'b0;
      rand_e();
      cycle();
      rand_e();
      E_Reg_Addr = 5'd5; E_Reg_WriteEn = 1'b1; E_Reg_Data_Sel = 2'b00;
      E_ALU_Result = 32'h1234; E_T_new = 3'd1;
      cycle();
      chk("t2_addr", {27'd0, FWD_M_Reg_Addr}, 32'd5);
      chk("t2_data", FWD_M_Reg_Data, 32'h1234);
      chk("t2_tnew", {29'd0, FWD_M_T_new}, 32'd0);
      chk("t2_we", {31'd0, FWD_M_Reg_WriteEn}, 32'd1);
      rand_e();
      E_Reg_Data_Sel = 2'b01; E_PC = 32'h3000; E_Reg_Addr = 5'd31;
      E_Reg_WriteEn = 1'b1; E_T_new = 3'd0;
      cycle();
      chk("t3_data", FWD_M_Reg_Data, 32'h3008);
      chk("t3_tnew", {29'd0, FWD_M_T_new}, 32'd0);
      chk("t3_addr31", {27'd0, FWD_M_Reg_Addr}, 32'd31);
      rand_e();
      E_Reg_Addr = 5'd0; E_Reg_WriteEn = 1'b1;
      cycle();
      chk("t3_we0", {31'd0, FWD_M_Reg_WriteEn}, 32'd0);
      chk("t3_addr0", {27'd0, FWD_M_Reg_Addr}, 32'd0);
      rand_e();
      E_T_new = 3'd2; E_Reg_Addr = 5'd9; E_Reg_WriteEn = 1'b1; E_Reg_Data_Sel = 2'b10;
      E_MDU_Out = 32'hCAFE_0001;
      cycle();
      chk("t4_load_tnew", {29'd0, FWD_M_T_new}, 32'd1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_e();
         cycle();
         chk("t4_stall_tnew", {29'd0, FWD_M_T_new}, 32'd1);
         chk("t4_stall_data", FWD_M_Reg_Data, 32'hCAFE_0001);
      end
      stall = 1'b0;
      flush = 1'b1;
      rand_e();
      E_PC = 32'h3010; E_BD = 1'b1;
      cycle();
      chk("t5_flush_pc", M_PC, 32'h3010);
      chk("t5_flush_bd", {31'd0, M_BD}, 32'd1);
      chk("t5_flush_we", {31'd0, FWD_M_Reg_WriteEn}, 32'd0);
      chk("t5_flush_instr", M_Instr, 32'd0);
      flush = 1'b0;
      req = 1'b1; stall = 1'b1;
      rand_e();
      cycle();
      chk("t5_req_pc", M_PC, EXC);
      chk("t5_req_bd", {31'd0, M_BD}, 32'd0);
      chk("t5_req_data", FWD_M_Reg_Data, 32'd0);
      req = 1'b0; flush = 1'b1;
      rand_e();
      cycle();
      chk("t5_flush_stall_pc", M_PC, E_PC);
      {req, flush, stall} = 3'b000;
      for (int i = 0; i < 100; i++) begin
         rand_e();
         cycle();
      end
      for (int i = 0; i < 200; i++) begin
         rand_e();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         req = ($urandom_range(0, 11) == 0);
         reset = ($urandom_range(0, 29) == 0);
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
